// File: rtl/sti_pkg.sv
// sti_pkg: definitions shared by the serial receiver and transmitter.
//   LEN8..LEN32   : frame length encodings for the 2-bit cfg_length field
//   sti_state_e   : serial frame state (idle / receiving)
//   bits_per_len  : number of serial bits in a frame of a given length code
package sti_pkg;

  localparam logic [1:0] LEN8  = 2'd0;
  localparam logic [1:0] LEN16 = 2'd1;
  localparam logic [1:0] LEN24 = 2'd2;
  localparam logic [1:0] LEN32 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } sti_state_e;

  // 8 * (len + 1); the largest result (32) still fits in 6 bits.
  function automatic logic [5:0] bits_per_len(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_rx_extract.sv
// sti_rx_extract: selects the 16-bit payload out of a completed 32-bit frame.
//   frame_i   : assembled frame, first-received bit placement already applied
//   len_i     : latched frame length code
//   fill_i    : 24/32-bit frames, 1 = payload in the upper 16 frame bits
//   low_i     : 8-bit frames, 1 = byte goes to payload[15:8]
//   payload_o : 16-bit payload (purely combinational)
module sti_rx_extract
  import sti_pkg::*;
(
  input  logic [31:0] frame_i,
  input  logic [1:0]  len_i,
  input  logic        fill_i,
  input  logic        low_i,
  output logic [15:0] payload_o
);

  always_comb begin
    payload_o = '0;
    case (len_i)
      LEN8:    payload_o = low_i  ? {frame_i[7:0], 8'h00} : {8'h00, frame_i[7:0]};
      LEN16:   payload_o = frame_i[15:0];
      LEN24:   payload_o = fill_i ? frame_i[23:8]  : frame_i[15:0];
      default: payload_o = fill_i ? frame_i[31:16] : frame_i[15:0];
    endcase
  end

endmodule

// File: rtl/sti_rx.sv
// sti_rx: serial-to-parallel receiver with a one-word output holding register.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   si_data      : serial bit, sampled while si_valid=1
//   si_valid     : bit qualifier, contiguous for the bits of a frame
//   cfg_length   : frame length code (8/16/24/32 bits), latched on first bit
//   cfg_msb      : 1 = first bit is frame MSB, 0 = LSB first
//   cfg_fill     : 24/32-bit frames, payload in upper (1) or lower (0) 16 bits
//   cfg_low      : 8-bit frames, byte placed in [15:8] (1) or [7:0] (0)
//   po_ready     : downstream accepts po_data while po_valid=1
//   po_data      : recovered 16-bit payload
//   po_valid     : po_data holds an unconsumed word
//   err_frame    : one-cycle pulse, frame truncated by si_valid dropping
//   err_overrun  : one-cycle pulse, completed word dropped (holding reg full)
module sti_rx
  import sti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        cfg_fill,
  input  logic        cfg_low,
  input  logic        po_ready,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        err_frame,
  output logic        err_overrun
);

  sti_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic [1:0]  len_q, len_d;
  logic        msb_q, msb_d;
  logic        fill_q, fill_d;
  logic        low_q, low_d;
  logic        done_q, done_d;
  logic        err_frame_q, err_frame_d;
  logic        err_overrun_q;
  logic        po_valid_q;
  logic [15:0] po_data_q;

  logic        start;
  logic        eff_msb;
  logic [1:0]  eff_len;
  logic [31:0] base_sr;
  logic [5:0]  base_cnt;
  logic [5:0]  cnt_inc;
  logic [15:0] payload;

  // A bit is the first of a frame when nothing is in flight: either idle, or
  // the previous frame just completed (counter wrapped to 0) and si_valid
  // continued. The first bit uses the live cfg inputs; later bits the latched.
  assign start    = si_valid && ((state_q == ST_IDLE) || (cnt_q == 6'd0));
  assign eff_msb  = start ? cfg_msb    : msb_q;
  assign eff_len  = start ? cfg_length : len_q;
  assign base_sr  = start ? 32'd0      : sr_q;
  assign base_cnt = start ? 6'd0       : cnt_q;
  assign cnt_inc  = base_cnt + 6'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    len_d       = len_q;
    msb_d       = msb_q;
    fill_d      = fill_q;
    low_d       = low_q;
    done_d      = 1'b0;
    err_frame_d = 1'b0;

    if (si_valid) begin
      if (start) begin
        state_d = ST_RECV;
        len_d   = cfg_length;
        msb_d   = cfg_msb;
        fill_d  = cfg_fill;
        low_d   = cfg_low;
      end
      if (eff_msb) begin
        sr_d = {base_sr[30:0], si_data};
      end else begin
        sr_d = base_sr;
        sr_d[base_cnt[4:0]] = si_data;
      end
      // On completion the counter wraps so the next valid bit starts a frame;
      // sr_q keeps the finished frame for the extract stage one cycle later.
      if (cnt_inc == bits_per_len(eff_len)) begin
        cnt_d  = 6'd0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (state_q == ST_RECV) begin
      state_d = ST_IDLE;
      cnt_d   = 6'd0;
      if (cnt_q != 6'd0) begin
        err_frame_d = 1'b1;
        sr_d        = '0;
      end
    end
  end

  sti_rx_extract u_extract (
    .frame_i   (sr_q),
    .len_i     (len_q),
    .fill_i    (fill_q),
    .low_i     (low_q),
    .payload_o (payload)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sr_q          <= '0;
      len_q         <= LEN8;
      msb_q         <= 1'b0;
      fill_q        <= 1'b0;
      low_q         <= 1'b0;
      done_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      po_valid_q    <= 1'b0;
      po_data_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      len_q       <= len_d;
      msb_q       <= msb_d;
      fill_q      <= fill_d;
      low_q       <= low_d;
      done_q      <= done_d;
      err_frame_q <= err_frame_d;

      // Holding register: a completed word loads when the slot is empty or
      // is being consumed this same edge; otherwise the new word is lost.
      err_overrun_q <= done_q && po_valid_q && !po_ready;
      if (done_q && (!po_valid_q || po_ready)) begin
        po_data_q  <= payload;
        po_valid_q <= 1'b1;
      end else if (po_valid_q && po_ready) begin
        po_valid_q <= 1'b0;
      end
    end
  end

  assign po_data     = po_data_q;
  assign po_valid    = po_valid_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;

endmodule
